// File: rtl/ov5640_init_readback.sv
`default_nettype none
// ============================================================================
//  Module      : ov5640_init_readback
//  Description : Post-configuration readback checker for the OV5640 init
//                table. Walks the {addr16,data8} init ROM from index 0 to
//                TABLE_LEN-1 and issues one SCCB read per entry, skipping
//                two self-clearing registers. Each returned byte is compared
//                with the table value. At the end of the pass the block
//                reports pass/fail, the number of mismatches plus bus errors,
//                and the first offending entry. It is intended for bring-up
//                and debug only and is not in the pixel path.
//
//  Optional feature macro:
//      OV5640_READBACK_TIMEOUT_EN - per-read watchdog. If no ack or error
//      arrives within TIMEOUT_CYCLES cycles of the request, the read is
//      abandoned and counted as an error. Without the macro a read that is
//      never acknowledged stalls the pass indefinitely.
//
//  Ports:
//      clk          system clock
//      rst          synchronous active-high reset
//      start_i      1-cycle pulse, begins a pass (ignored while busy)
//      rom_addr_o   table index to the registered init ROM
//      rom_q_i      ROM word {addr16,data8}, 1 cycle after rom_addr_o
//      rd_req_o     SCCB read request, held until ack/err (or timeout)
//      rd_addr_o    register address for the SCCB read
//      rd_ack_i     1-cycle read-complete pulse, qualifies rd_data_i
//      rd_data_i    byte returned by the sensor
//      rd_err_i     1-cycle NACK/bus-error pulse for the current read
//      busy_o       high from the cycle after start until done
//      done_o       1-cycle pulse at the end of a pass
//      pass_o       1 = no mismatches and no errors (valid after done)
//      mism_cnt_o   mismatches plus errors, saturating at all-ones
//      first_idx_o  table index of the first mismatch/error
//      first_exp_o  expected byte at first_idx_o
//      first_got_o  received byte at first_idx_o (8'h00 for an error)
//
//  Revision    : 1.0  initial release
// ============================================================================
module ov5640_init_readback #(
    parameter int          ADDR_WIDTH     = 8,
    parameter int          TABLE_LEN      = 252,
    parameter logic [15:0] SKIP_ADDR0     = 16'h3008,
    parameter logic [15:0] SKIP_ADDR1     = 16'h3002,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [23:0]           rom_q_i,
    output logic                  rd_req_o,
    output logic [15:0]           rd_addr_o,
    input  logic                  rd_ack_i,
    input  logic [7:0]            rd_data_i,
    input  logic                  rd_err_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH:0]   mism_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_idx_o,
    output logic [7:0]            first_exp_o,
    output logic [7:0]            first_got_o
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity: the table must be non-empty and fit
    // in the ROM address space, and the watchdog needs at least one cycle.
    // ------------------------------------------------------------------------
    if ((TABLE_LEN < 1) || (TABLE_LEN > (1 << ADDR_WIDTH)) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("ov5640_init_readback: illegal TABLE_LEN/ADDR_WIDTH/TIMEOUT_CYCLES combination");
    end

    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = ADDR_WIDTH'(TABLE_LEN - 1);

`ifdef OV5640_READBACK_TIMEOUT_EN
    // Watchdog counts 0 .. TIMEOUT_CYCLES-1 while a request is outstanding.
    localparam int                 c_TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
`endif

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SET     = 4'd1,   // present the table index to the ROM
        S_WAIT    = 4'd2,   // ROM register latency
        S_LATCH   = 4'd3,   // capture the ROM word
        S_SKIPCHK = 4'd4,   // drop self-clearing registers without a read
        S_REQ     = 4'd5,   // raise the SCCB read request
        S_ACK     = 4'd6,   // hold the request until ack/err (or timeout)
        S_CMP     = 4'd7,   // compare and record the first event
        S_NEXT    = 4'd8,   // advance or finish
        S_FIN     = 4'd9    // report results
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [ADDR_WIDTH-1:0]   rom_addr_q;
    logic [23:0]             entry_q;
    logic                    rd_req_q;
    logic [15:0]             rd_addr_q;
    logic                    err_q;
    logic [7:0]              got_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic [ADDR_WIDTH:0]     mism_cnt_q;
    logic [ADDR_WIDTH-1:0]   first_idx_q;
    logic [7:0]              first_exp_q;
    logic [7:0]              first_got_q;
`ifdef OV5640_READBACK_TIMEOUT_EN
    logic [c_TMR_W-1:0]      tmr_q;
`endif

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                    skip_d;
    logic                    event_d;
    logic [ADDR_WIDTH:0]     mism_cnt_d;

    always_comb begin
        skip_d     = (entry_q[23:8] == SKIP_ADDR0) || (entry_q[23:8] == SKIP_ADDR1);
        // An errored read always counts, whatever byte happened to be latched.
        event_d    = err_q || (got_q != entry_q[7:0]);
        // Saturating increment: holds at all-ones instead of wrapping to 0,
        // which would otherwise make a badly broken sensor look clean.
        mism_cnt_d = (&mism_cnt_q) ? mism_cnt_q : (mism_cnt_q + 1'b1);
    end

    // ------------------------------------------------------------------------
    // Sequencer with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rom_addr_q  <= '0;
            entry_q     <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            err_q       <= 1'b0;
            got_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            mism_cnt_q  <= '0;
            first_idx_q <= '0;
            first_exp_q <= '0;
            first_got_q <= '0;
`ifdef OV5640_READBACK_TIMEOUT_EN
            tmr_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        idx_q       <= '0;
                        mism_cnt_q  <= '0;
                        first_idx_q <= '0;
                        first_exp_q <= '0;
                        first_got_q <= '0;
                        pass_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_SET;
                    end
                end

                S_SET: begin
                    rom_addr_q <= idx_q;
                    state_q    <= S_WAIT;
                end

                S_WAIT: begin
                    state_q <= S_LATCH;
                end

                S_LATCH: begin
                    entry_q <= rom_q_i;
                    state_q <= S_SKIPCHK;
                end

                S_SKIPCHK: begin
                    state_q <= skip_d ? S_NEXT : S_REQ;
                end

                S_REQ: begin
                    rd_req_q  <= 1'b1;
                    rd_addr_q <= entry_q[23:8];
`ifdef OV5640_READBACK_TIMEOUT_EN
                    tmr_q     <= '0;
`endif
                    state_q   <= S_ACK;
                end

                S_ACK: begin
                    if (rd_ack_i || rd_err_i) begin
                        // A simultaneous ack and err is treated as an error.
                        rd_req_q <= 1'b0;
                        err_q    <= rd_err_i;
                        got_q    <= rd_err_i ? 8'h00 : rd_data_i;
                        state_q  <= S_CMP;
                    end
`ifdef OV5640_READBACK_TIMEOUT_EN
                    else if (tmr_q == c_TMR_LAST) begin
                        rd_req_q <= 1'b0;
                        err_q    <= 1'b1;
                        got_q    <= 8'h00;
                        state_q  <= S_CMP;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
`endif
                end

                S_CMP: begin
                    if (event_d) begin
                        mism_cnt_q <= mism_cnt_d;
                        // Count never returns to zero within a pass, so zero
                        // identifies the first event.
                        if (mism_cnt_q == '0) begin
                            first_idx_q <= idx_q;
                            first_exp_q <= entry_q[7:0];
                            first_got_q <= got_q;
                        end
                    end
                    state_q <= S_NEXT;
                end

                S_NEXT: begin
                    if (idx_q == c_LAST_IDX) begin
                        state_q <= S_FIN;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= S_SET;
                    end
                end

                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    pass_q  <= (mism_cnt_q == '0);
                    state_q <= S_IDLE;
                end

                default: begin
                    rd_req_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rom_addr_o  = rom_addr_q;
    assign rd_req_o    = rd_req_q;
    assign rd_addr_o   = rd_addr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign mism_cnt_o  = mism_cnt_q;
    assign first_idx_o = first_idx_q;
    assign first_exp_o = first_exp_q;
    assign first_got_o = first_got_q;

endmodule
`default_nettype wire

// File: tb/tb_ov5640_init_readback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ov5640_init_readback
//  Description : Self-checking bench for ov5640_init_readback. A registered
//                ROM model and a randomized SCCB responder drive the DUT;
//                expected results come from a per-entry walk of the table
//                in a behavioural model function.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ov5640_init_readback;

    localparam int AW = 8;
    localparam int TL = 252;
    localparam int TO = 16;

    // Responder behaviour per table index
    localparam logic [2:0] K_ECHO   = 3'd0;
    localparam logic [2:0] K_VALUE  = 3'd1;
    localparam logic [2:0] K_ERR    = 3'd2;
    localparam logic [2:0] K_ACKERR = 3'd3;
    localparam logic [2:0] K_SILENT = 3'd4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] rom_addr_o;
    logic [23:0]   rom_q = '0;
    logic          rd_req_o;
    logic [15:0]   rd_addr_o;
    logic          rd_ack = 1'b0;
    logic [7:0]    rd_data = '0;
    logic          rd_err = 1'b0;
    logic          busy_o, done_o, pass_o;
    logic [AW:0]   mism_cnt_o;
    logic [AW-1:0] first_idx_o;
    logic [7:0]    first_exp_o, first_got_o;

    logic [23:0]   rom  [0:255];
    logic [2:0]    kind [0:255];
    logic [7:0]    val  [0:255];

    logic [15:0]   reads_q[$];
    int            addr_bad = 0;
    bit            stray_en = 1'b0;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    ov5640_init_readback #(
        .ADDR_WIDTH     (AW),
        .TABLE_LEN      (TL),
        .SKIP_ADDR0     (16'h3008),
        .SKIP_ADDR1     (16'h3002),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .rom_addr_o  (rom_addr_o),
        .rom_q_i     (rom_q),
        .rd_req_o    (rd_req_o),
        .rd_addr_o   (rd_addr_o),
        .rd_ack_i    (rd_ack),
        .rd_data_i   (rd_data),
        .rd_err_i    (rd_err),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .mism_cnt_o  (mism_cnt_o),
        .first_idx_o (first_idx_o),
        .first_exp_o (first_exp_o),
        .first_got_o (first_got_o)
    );

    // Registered init ROM
    always @(posedge clk) rom_q <= rom[rom_addr_o];

    // SCCB responder: random response delay, per-index behaviour, and
    // optional stray ack/err pulses while no request is outstanding.
    initial begin : responder
        bit prev_req;
        int dly;
        prev_req = 1'b0;
        dly      = -1;
        forever begin
            @(posedge clk);
            #1;
            rd_ack = 1'b0;
            rd_err = 1'b0;
            if (rd_req_o === 1'b1) begin
                if (!prev_req) begin
                    reads_q.push_back(rd_addr_o);
                    if (rd_addr_o !== rom[rom_addr_o][23:8]) addr_bad++;
                    dly = int'($urandom_range(0, 3));
                end
                prev_req = 1'b1;
                if (dly == 0) begin
                    case (kind[rom_addr_o])
                        K_ECHO:   begin rd_ack = 1'b1; rd_data = rom[rom_addr_o][7:0]; end
                        K_VALUE:  begin rd_ack = 1'b1; rd_data = val[rom_addr_o]; end
                        K_ERR:    begin rd_err = 1'b1; rd_data = 8'($urandom); end
                        K_ACKERR: begin rd_ack = 1'b1; rd_err = 1'b1; rd_data = 8'($urandom); end
                        default:  ;
                    endcase
                    dly = -1;
                end else if (dly > 0) begin
                    dly--;
                end
            end else begin
                prev_req = 1'b0;
                if (stray_en && busy_o === 1'b1 && $urandom_range(0, 7) == 0) begin
                    rd_ack  = 1'($urandom_range(0, 1));
                    rd_err  = ~rd_ack;
                    rd_data = 8'($urandom);
                end
            end
        end
    end

    // Global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Reference model: walk the table, skip the two special registers, and
    // classify each remaining entry from the responder behaviour.
    // ------------------------------------------------------------------------
    function automatic void model(output int mc, output int fi, output logic [7:0] fe,
                                  output logic [7:0] fg, output int nr);
        logic [15:0] a;
        logic [7:0]  got;
        bit          ev;
        mc = 0; fi = 0; fe = 8'h00; fg = 8'h00; nr = 0;
        for (int i = 0; i < TL; i++) begin
            a = rom[i][23:8];
            if (a == 16'h3008 || a == 16'h3002) continue;
            nr++;
            case (kind[i])
                K_ECHO:  begin got = rom[i][7:0]; ev = 1'b0; end
                K_VALUE: begin got = val[i]; ev = (got != rom[i][7:0]); end
                default: begin got = 8'h00; ev = 1'b1; end
            endcase
            if (ev) begin
                if (mc == 0) begin fi = i; fe = rom[i][7:0]; fg = got; end
                if (mc < (1 << (AW + 1)) - 1) mc++;
            end
        end
    endfunction

    task automatic clear_kinds();
        for (int i = 0; i < 256; i++) begin kind[i] = K_ECHO; val[i] = 8'h00; end
        reads_q.delete();
        addr_bad = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit to, output int dw, output logic b_at_done);
        to = 1'b1; dw = 0; b_at_done = 1'bx;
        for (int c = 0; c < limit; c++) begin
            if (done_o === 1'b1) begin to = 1'b0; break; end
            @(posedge clk); #1;
        end
        if (!to) begin
            b_at_done = busy_o;
            while (done_o === 1'b1 && dw < 4) begin dw++; @(posedge clk); #1; end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({busy_o, done_o, pass_o, rd_req_o} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_flags: got %b exp 0000", {busy_o, done_o, pass_o, rd_req_o}); end
        n_checks++; if (mism_cnt_o !== '0 || rom_addr_o !== '0 || rd_addr_o !== '0) begin n_fail++;
            $display("FAIL reset_counts: mism %0h rom_addr %0h rd_addr %0h exp 0", mism_cnt_o, rom_addr_o, rd_addr_o); end
        n_checks++; if ({first_idx_o, first_exp_o, first_got_o} !== 24'h0) begin n_fail++;
            $display("FAIL reset_first: got %h exp 000000", {first_idx_o, first_exp_o, first_got_o}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_echo();
        bit to; int dw; logic bd; int mc, fi, nr, nskip; logic [7:0] fe, fg;
        clear_kinds();
        model(mc, fi, fe, fg, nr);
        pulse_start();
        n_checks++; if ({busy_o, done_o, pass_o} !== 3'b100) begin n_fail++;
            $display("FAIL echo_busy_after_start: busy/done/pass %b exp 100", {busy_o, done_o, pass_o}); end
        wait_done(20000, to, dw, bd);
        n_checks++; if (to) begin n_fail++; $display("FAIL echo_timeout: done not seen, exp done"); end
        n_checks++; if (dw !== 1 || bd !== 1'b0) begin n_fail++;
            $display("FAIL echo_done_pulse: width %0d busy %b exp 1/0", dw, bd); end
        n_checks++; if (pass_o !== 1'b1 || mism_cnt_o !== 9'(mc)) begin n_fail++;
            $display("FAIL echo_result: pass %b mism %0d exp 1/%0d", pass_o, mism_cnt_o, mc); end
        nskip = 0;
        foreach (reads_q[i]) if (reads_q[i] == 16'h3008 || reads_q[i] == 16'h3002) nskip++;
        n_checks++; if (nskip != 0 || reads_q.size() != nr || addr_bad != 0) begin n_fail++;
            $display("FAIL echo_reads: skipped-reads %0d count %0d badaddr %0d exp 0/%0d/0", nskip, reads_q.size(), addr_bad, nr); end
    endtask

    task automatic test_single_mismatch();
        bit to; int dw; logic bd; int mc, fi, nr; logic [7:0] fe, fg;
        clear_kinds();
        kind[56] = K_VALUE; val[56] = 8'h00;
        model(mc, fi, fe, fg, nr);
        pulse_start();
        wait_done(20000, to, dw, bd);
        n_checks++; if (to || pass_o !== 1'b0 || mism_cnt_o !== 9'(mc)) begin n_fail++;
            $display("FAIL mism56_result: to %b pass %b mism %0d exp 0/0/%0d", to, pass_o, mism_cnt_o, mc); end
        n_checks++; if (first_idx_o !== 8'(fi) || first_exp_o !== fe || first_got_o !== fg) begin n_fail++;
            $display("FAIL mism56_first: idx %0d exp %h got %h, required %0d/%h/%h", first_idx_o, first_exp_o, first_got_o, fi, fe, fg); end
    endtask

    task automatic test_err_and_mismatch();
        bit to; int dw; logic bd; int mc, fi, nr; logic [7:0] fe, fg;
        clear_kinds();
        kind[5]  = K_ERR;
        kind[10] = K_VALUE; val[10] = rom[10][7:0] ^ 8'h5a;
        stray_en = 1'b1;
        model(mc, fi, fe, fg, nr);
        pulse_start();
        wait_done(20000, to, dw, bd);
        stray_en = 1'b0;
        n_checks++; if (to || pass_o !== 1'b0 || mism_cnt_o !== 9'(mc)) begin n_fail++;
            $display("FAIL errmism_result: to %b pass %b mism %0d exp 0/0/%0d", to, pass_o, mism_cnt_o, mc); end
        n_checks++; if (first_idx_o !== 8'(fi) || first_exp_o !== fe || first_got_o !== fg) begin n_fail++;
            $display("FAIL errmism_first: idx %0d exp %h got %h, required %0d/%h/%h", first_idx_o, first_exp_o, first_got_o, fi, fe, fg); end
    endtask

    task automatic test_ackerr_and_busy_start();
        bit to; int dw; logic bd; int mc, fi, nr; logic [7:0] fe, fg;
        clear_kinds();
        kind[0] = K_ACKERR;
        model(mc, fi, fe, fg, nr);
        pulse_start();
        repeat (40) @(posedge clk);
        #1;
        pulse_start();
        wait_done(20000, to, dw, bd);
        n_checks++; if (to || mism_cnt_o !== 9'(mc) || first_idx_o !== 8'(fi) || first_got_o !== fg) begin n_fail++;
            $display("FAIL ackerr_result: to %b mism %0d idx %0d got %h exp %0d/%0d/%h", to, mism_cnt_o, first_idx_o, first_got_o, mc, fi, fg); end
        n_checks++; if (reads_q.size() != nr || pass_o !== 1'b0) begin n_fail++;
            $display("FAIL busy_start_ignored: reads %0d pass %b exp %0d/0", reads_q.size(), pass_o, nr); end
    endtask

    task automatic test_random();
        bit to; int dw; logic bd; int mc, fi, nr, nev, i; logic [7:0] fe, fg;
        for (int it = 0; it < 4; it++) begin
            clear_kinds();
            nev = int'($urandom_range(0, 4));
            for (int e = 0; e < nev; e++) begin
                i = int'($urandom_range(0, TL - 1));
                kind[i] = 3'($urandom_range(1, 3));
                val[i]  = 8'($urandom);
            end
            stray_en = 1'b1;
            model(mc, fi, fe, fg, nr);
            pulse_start();
            wait_done(20000, to, dw, bd);
            stray_en = 1'b0;
            n_checks++; if (to || pass_o !== (mc == 0) || mism_cnt_o !== 9'(mc) || reads_q.size() != nr) begin n_fail++;
                $display("FAIL random%0d_result: to %b pass %b mism %0d reads %0d exp %b/%0d/%0d", it, to, pass_o, mism_cnt_o, reads_q.size(), (mc == 0), mc, nr); end
            n_checks++; if (first_idx_o !== 8'(fi) || first_exp_o !== fe || first_got_o !== fg) begin n_fail++;
                $display("FAIL random%0d_first: idx %0d exp %h got %h, required %0d/%h/%h", it, first_idx_o, first_exp_o, first_got_o, fi, fe, fg); end
        end
    endtask

    task automatic test_reset_mid_pass();
        bit to, seen; int dw; logic bd; int mc, fi, nr; logic [7:0] fe, fg;
        clear_kinds();
        kind[10] = K_ERR;
        kind[20] = K_ERR;
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (rd_req_o === 1'b1 && rom_addr_o == 8'd100) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (!seen || mism_cnt_o !== 9'd2) begin n_fail++;
            $display("FAIL midreset_reach_idx100: seen %b mism %0d exp 1/2", seen, mism_cnt_o); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({rd_req_o, busy_o, done_o} !== 3'b000 || mism_cnt_o !== '0) begin n_fail++;
            $display("FAIL midreset_abort: req/busy/done %b mism %0d exp 000/0", {rd_req_o, busy_o, done_o}, mism_cnt_o); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (done_o === 1'b1 || busy_o === 1'b1) seen = 1'b1; end
        n_checks++; if (seen) begin n_fail++; $display("FAIL midreset_no_done: activity after reset, exp idle"); end
        clear_kinds();
        model(mc, fi, fe, fg, nr);
        pulse_start();
        wait_done(20000, to, dw, bd);
        n_checks++; if (to || pass_o !== 1'b1 || mism_cnt_o !== 9'(mc) || reads_q.size() != nr) begin n_fail++;
            $display("FAIL midreset_rerun: to %b pass %b mism %0d reads %0d exp 0/1/%0d/%0d", to, pass_o, mism_cnt_o, reads_q.size(), mc, nr); end
    endtask

    task automatic test_timeout();
        bit to, seen; int dw, n; logic bd;
        clear_kinds();
        kind[3] = K_SILENT;
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (rd_req_o === 1'b1 && rom_addr_o == 8'd3) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL timeout_req_idx3: request not seen, exp seen"); end
`ifdef OV5640_READBACK_TIMEOUT_EN
        n = 0;
        while (rd_req_o === 1'b1 && n < 100) begin n++; @(posedge clk); #1; end
        n_checks++; if (n != TO) begin n_fail++; $display("FAIL timeout_req_width: %0d cycles exp %0d", n, TO); end
        wait_done(20000, to, dw, bd);
        n_checks++; if (to || pass_o !== 1'b0 || mism_cnt_o !== 9'd1) begin n_fail++;
            $display("FAIL timeout_result: to %b pass %b mism %0d exp 0/0/1", to, pass_o, mism_cnt_o); end
        n_checks++; if (first_idx_o !== 8'd3 || first_got_o !== 8'h00 || first_exp_o !== rom[3][7:0]) begin n_fail++;
            $display("FAIL timeout_first: idx %0d got %h exp %h, required 3/00/%h", first_idx_o, first_got_o, first_exp_o, rom[3][7:0]); end
`else
        n = 0;
        repeat (300) begin @(posedge clk); #1; if (rd_req_o === 1'b1 && busy_o === 1'b1 && done_o === 1'b0) n++; end
        n_checks++; if (n != 300) begin n_fail++; $display("FAIL stall_no_timeout: held %0d of 300 cycles exp 300", n); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
`endif
    endtask

    // ------------------------------------------------------------------------
    initial begin : main
        logic [15:0] a;
        for (int i = 0; i < 256; i++) begin
            do a = 16'($urandom_range(16'h3000, 16'h5fff));
            while (a == 16'h3008 || a == 16'h3002 || a == 16'h4300);
            rom[i] = {a, 8'($urandom)};
        end
        rom[1]   = {16'h3008, 8'h82};
        rom[2]   = {16'h3002, 8'h1c};
        rom[200] = {16'h3008, 8'h02};
        rom[56]  = {16'h4300, 8'h6f};
        clear_kinds();

        test_reset();
        test_echo();
        test_single_mismatch();
        test_err_and_mismatch();
        test_ackerr_and_busy_start();
        test_random();
        test_reset_mid_pass();
        test_timeout();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
